dff: RTL and testbench

//   Edge-triggered D flip-flop with load enable and synchronous active-high reset.

---
 rtl/dff.sv | 23 ++
 tb/tb_dff.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dff.sv
// General-purpose D register with load enable and synchronous active-high reset.
// Port order (CK, D, Q, LD, RES) is fixed because existing instances connect by position.
module dff #(
   parameter int unsigned           WIDTH   = 1,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic             CK,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   input  logic             LD,
   input  logic             RES
);

   // Reset outranks load; with neither asserted Q holds.
   always_ff @(posedge CK) begin
      if (RES) begin
         Q <= RST_VAL;
      end else if (LD) begin
         Q <= D;
      end
   end

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: a 1-bit default instance and an 8-bit instance with RST_VAL=8'hA5
// share CK/LD/RES and are stepped through a vector table plus a held-reset sequence.
`timescale 1ns/1ps
module tb_dff;

   logic       ck;
   logic       ld;
   logic       res;
   logic       d1;
   logic       q1;
   logic [7:0] d8;
   logic [7:0] q8;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   dff u_dff1 (
      .CK  (ck),
      .D   (d1),
      .Q   (q1),
      .LD  (ld),
      .RES (res)
   );

   dff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dff8 (
      .CK  (ck),
      .D   (d8),
      .Q   (q8),
      .LD  (ld),
      .RES (res)
   );

   // 100 ns period; rising edges at 50, 150, 250, ...
   initial ck = 1'b0;
   always #50 ck = ~ck;

   typedef struct packed {
      logic       res;
      logic       ld;
      logic       d1;
      logic [7:0] d8;
      logic       exp1;
      logic [7:0] exp8;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin
      // Reset edge, hold, load, follow, hold with D toggling, reset-vs-load, reload.
      vecs[0]  = '{res:1'b1, ld:1'b0, d1:1'b0, d8:8'hFF, exp1:1'b0, exp8:8'hA5};
      vecs[1]  = '{res:1'b0, ld:1'b0, d1:1'b0, d8:8'h00, exp1:1'b0, exp8:8'hA5};
      vecs[2]  = '{res:1'b0, ld:1'b1, d1:1'b0, d8:8'h3C, exp1:1'b0, exp8:8'h3C};
      vecs[3]  = '{res:1'b0, ld:1'b1, d1:1'b1, d8:8'hC3, exp1:1'b1, exp8:8'hC3};
      vecs[4]  = '{res:1'b0, ld:1'b1, d1:1'b0, d8:8'h00, exp1:1'b0, exp8:8'h00};
      vecs[5]  = '{res:1'b0, ld:1'b1, d1:1'b1, d8:8'h5A, exp1:1'b1, exp8:8'h5A};
      vecs[6]  = '{res:1'b0, ld:1'b0, d1:1'b0, d8:8'h11, exp1:1'b1, exp8:8'h5A};
      vecs[7]  = '{res:1'b0, ld:1'b0, d1:1'b1, d8:8'h22, exp1:1'b1, exp8:8'h5A};
      vecs[8]  = '{res:1'b0, ld:1'b0, d1:1'b0, d8:8'h33, exp1:1'b1, exp8:8'h5A};
      vecs[9]  = '{res:1'b1, ld:1'b1, d1:1'b1, d8:8'hFF, exp1:1'b0, exp8:8'hA5};
      vecs[10] = '{res:1'b0, ld:1'b1, d1:1'b1, d8:8'h3C, exp1:1'b1, exp8:8'h3C};

      res = 1'b0;
      ld  = 1'b0;
      d1  = 1'b0;
      d8  = 8'h00;

      // One edge with no reset; Q is undefined here and not checked.
      @(posedge ck);
      #25;

      for (int i = 0; i < 11; i++) begin
         res = vecs[i].res;
         ld  = vecs[i].ld;
         d1  = vecs[i].d1;
         d8  = vecs[i].d8;
         #50;
         // Mid-cycle: new inputs must not reach Q before the edge.
         if (i > 0) begin
            check($sformatf("mid1[%0d]", i), 8'(q1), 8'(vecs[i-1].exp1));
            check($sformatf("mid8[%0d]", i), q8, vecs[i-1].exp8);
         end
         @(posedge ck);
         #25;
         check($sformatf("q1[%0d]", i), 8'(q1), 8'(vecs[i].exp1));
         check($sformatf("q8[%0d]", i), q8, vecs[i].exp8);
      end

      // Reset held over two edges with LD=1 discards loads; loading resumes on release.
      res = 1'b1;
      ld  = 1'b1;
      d1  = 1'b1;
      d8  = 8'h77;
      for (int k = 0; k < 2; k++) begin
         @(posedge ck);
         #25;
         check($sformatf("hold_rst1[%0d]", k), 8'(q1), 8'h00);
         check($sformatf("hold_rst8[%0d]", k), q8, 8'hA5);
      end
      res = 1'b0;
      #50;
      check("pre_release8", q8, 8'hA5);
      @(posedge ck);
      #25;
      check("release1", 8'(q1), 8'h01);
      check("release8", q8, 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
